lsu_rmw: RTL and testbench

- Load/store initiator that sits between the CPU execute/memory stage and the word-only data memory.
- Turns CPU byte, halfword and word loads/stores into word accesses on the memory's combinational-read / posedge-write port.
- Performs read-modify-write for SB/SH.
- Sign/zero-extends load data and flags misaligned or out-of-range accesses.

---
 rtl/lsu_rmw.sv | 184 ++++++++++++++++++
 tb/tb_lsu_rmw.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// lsu_rmw: turns CPU byte/half/word loads and stores into word accesses on a
//   word-only data memory (combinational read, posedge write), with read-modify-write
//   for SB/SH, sign/zero extension of load data, and misalignment/range exceptions.
// Latency accept->resp_valid: load 2, SW 2, SB/SH 3, exception 1 cycle(s).
// Backpressure: req_ready only in IDLE (one op in flight); resp has no backpressure.
// Ports: req_* from the CPU execute/memory stage, resp_* back to it, mem_* to the
//   data memory (mem_pc feeds the memory's write log).
module lsu_rmw #(
   parameter int unsigned DM_BYTES = 12288
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_exc,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_pc,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SB  = 3'd7;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   // Only the low half of store data is needed after accept: SW data goes
   // straight into mem_wdata_q, SB/SH merge at most 16 bits.
   logic [15:0] wdata_q, wdata_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        exc_q, exc_d;

   logic        accept;
   logic        misaligned;
   logic        out_of_range;
   logic [31:0] rd_shift;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept       = req_valid && (state_q == ST_IDLE);
   assign misaligned   = (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00)) ||
                         (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && req_addr[0]);
   assign out_of_range = req_addr >= 32'(DM_BYTES);

   // Little-endian lane selection from the latched address.
   assign rd_shift  = mem_rdata >> {addr_q[1:0], 3'b000};
   assign byte_lane = rd_shift[7:0];
   assign half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      load_ext = mem_rdata;
      case (op_q)
         OP_LH:   load_ext = {{16{half_lane[15]}}, half_lane};
         OP_LHU:  load_ext = {16'h0000, half_lane};
         OP_LB:   load_ext = {{24{byte_lane[7]}}, byte_lane};
         OP_LBU:  load_ext = {24'h000000, byte_lane};
         default: load_ext = mem_rdata;
      endcase
   end

   // Current memory word with the target lane replaced by the store data.
   always_comb begin
      merged = mem_rdata;
      if (op_q == OP_SB) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q;
      end else begin
         merged[15:0] = wdata_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      pc_d        = pc_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      exc_d       = exc_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d    = req_op;
               addr_d  = req_addr;
               wdata_d = req_wdata[15:0];
               pc_d    = req_pc;
               if (misaligned || out_of_range) begin
                  rdata_d = 32'h0;
                  exc_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (req_op <= OP_LBU) begin
                  state_d = ST_LOAD;
               end else if (req_op == OP_SW) begin
                  mem_wdata_d = req_wdata;
                  state_d     = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_LOAD: begin
            rdata_d = load_ext;
            exc_d   = 1'b0;
            state_d = ST_RESP;
         end
         ST_READ: begin
            mem_wdata_d = merged;
            state_d     = ST_WRITE;
         end
         ST_WRITE: begin
            rdata_d = 32'h0;
            exc_d   = 1'b0;
            state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= 3'd0;
         addr_q      <= 32'h0;
         wdata_q     <= 16'h0;
         pc_q        <= 32'h0;
         mem_wdata_q <= 32'h0;
         rdata_q     <= 32'h0;
         exc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         pc_q        <= pc_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         exc_q       <= exc_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_exc   = exc_q;
   // Gated by reset so an op aborted in WRITE never reaches memory.
   assign mem_write  = (state_q == ST_WRITE) && !reset;
   assign mem_addr   = ((state_q == ST_LOAD) || (state_q == ST_READ) || (state_q == ST_WRITE)) ?
                       {addr_q[31:2], 2'b00} : 32'h0;
   assign mem_wdata  = mem_wdata_q;
   assign mem_pc     = pc_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed plus randomized checks of lsu_rmw against a byte-array
//   reference model of the data memory.
// Outputs are sampled 1 time unit after each rising edge; inputs driven at the same point.
module tb_lsu_rmw;
   localparam int DMB = 12288;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_exc;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_pc;
   logic [31:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   logic [31:0] dmem    [0:DMB/4-1];
   logic [7:0]  ref_mem [0:DMB-1];

   lsu_rmw #(.DM_BYTES(DMB)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_pc(mem_pc), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, posedge write.
   assign mem_rdata = (mem_addr < DMB) ? dmem[mem_addr[13:2]] : 32'h0;
   always @(posedge clk) if (mem_write && mem_addr < DMB) dmem[mem_addr[13:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input int a);
      int b;
      b = a - (a % 4);
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   // Reference: byte-addressed memory; stores update bytes, loads assemble them.
   task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic exc, output logic [31:0] rd, output logic [31:0] wr,
                        output int lat);
      int a, v, n;
      exc = (addr >= DMB) ||
            ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'b00) ||
            ((op == 3'd1 || op == 3'd2 || op == 3'd6) && addr[0]);
      rd  = 32'h0;
      wr  = 32'h0;
      lat = exc ? 1 : ((op == 3'd6 || op == 3'd7) ? 3 : 2);
      if (!exc) begin
         a = int'(addr);
         case (op)
            3'd0: rd = word_of(a);
            3'd1: begin v = ref_mem[a] + 256 * ref_mem[a+1]; if (v >= 32768) v -= 65536; rd = v; end
            3'd2: begin v = ref_mem[a] + 256 * ref_mem[a+1]; rd = v; end
            3'd3: begin v = ref_mem[a]; if (v >= 128) v -= 256; rd = v; end
            3'd4: begin v = ref_mem[a]; rd = v; end
            default: begin
               n = (op == 3'd5) ? 4 : ((op == 3'd6) ? 2 : 1);
               for (int k = 0; k < n; k++) ref_mem[a+k] = 8'((wdata >> (8 * k)) & 32'hFF);
               wr = word_of(a);
            end
         endcase
      end
   endtask

   // Issue one op (caller is 1 unit after a rising edge) and check its whole life.
   task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pc, output logic [31:0] rd_obs);
      logic exc_e; logic [31:0] rd_e, wr_e, wa, wd;
      int lat_e, c, wr_cnt, wr_cyc, w;
      bit done;
      model(op, addr, wdata, exc_e, rd_e, wr_e, lat_e);
      w = 0;
      while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
      check("ready_before_issue", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      c = 1; done = 1'b0; wr_cnt = 0; wr_cyc = 0; wa = 32'h0; wd = 32'h0;
      while (!done && c <= 8) begin
         check("mem_pc_held", mem_pc, pc);
         if (mem_write) begin wr_cnt++; wr_cyc = c; wa = mem_addr; wd = mem_wdata; end
         if (resp_valid) done = 1'b1;
         else begin @(posedge clk); #1; c++; end
      end
      check("latency", done ? c : 0, lat_e);
      check("resp_exc", {31'h0, resp_exc}, {31'h0, exc_e});
      check("resp_rdata", resp_rdata, rd_e);
      check("mem_addr_resp", mem_addr, 32'h0);
      check("write_count", wr_cnt, (!exc_e && op >= 3'd5) ? 1 : 0);
      if (!exc_e && op >= 3'd5) begin
         check("write_cycle", wr_cyc, lat_e - 1);
         check("write_addr", wa, {addr[31:2], 2'b00});
         check("write_data", wd, wr_e);
      end
      rd_obs = resp_rdata;
      @(posedge clk); #1;
      check("resp_pulse_once", {31'h0, resp_valid}, 32'h0);
      check("ready_after_resp", {31'h0, req_ready}, 32'h1);
      check("rdata_held", resp_rdata, rd_e);
   endtask

   initial begin
      logic [31:0] rd, rd_e, wr_e, ad, old_word;
      logic exc_e;
      int lat_e, r;
      logic [2:0] op;

      for (int i = 0; i < DMB / 4; i++) dmem[i] = 32'h0;
      for (int i = 0; i < DMB; i++) ref_mem[i] = 8'h0;
      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_exc", {31'h0, resp_exc}, 32'h0);
      check("rst_mem_write", {31'h0, mem_write}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_pc", mem_pc, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed lane, extension and merge cases.
      do_op(3'd5, 32'h10, 32'hDEADBEEF, 32'h100, rd);
      check("sw_dir_dmem", dmem[4], 32'hDEADBEEF);
      do_op(3'd5, 32'h10, 32'h8899AABB, 32'h104, rd);
      do_op(3'd3, 32'h13, 32'h0, 32'h108, rd); check("lb_dir", rd, 32'hFFFFFF88);
      do_op(3'd4, 32'h13, 32'h0, 32'h10C, rd); check("lbu_dir", rd, 32'h00000088);
      do_op(3'd1, 32'h10, 32'h0, 32'h110, rd); check("lh_dir", rd, 32'hFFFFAABB);
      do_op(3'd2, 32'h12, 32'h0, 32'h114, rd); check("lhu_dir", rd, 32'h00008899);
      do_op(3'd7, 32'h11, 32'h12345677, 32'h118, rd);
      check("sb_dir_dmem", dmem[4], 32'h889977BB);
      do_op(3'd6, 32'h12, 32'h0000CAFE, 32'h11C, rd);
      check("sh_dir_dmem", dmem[4], 32'hCAFE77BB);
      do_op(3'd0, 32'h10, 32'h0, 32'h120, rd); check("lw_dir", rd, 32'hCAFE77BB);

      // Exceptions and range boundaries.
      do_op(3'd0, 32'h2, 32'h0, 32'h200, rd);
      do_op(3'd6, 32'h1, 32'h1111, 32'h204, rd);
      do_op(3'd5, 32'h3000, 32'h12345678, 32'h208, rd);
      do_op(3'd5, 32'h2FFC, 32'hA5A5_5A5A, 32'h20C, rd);
      check("sw_last_word", dmem[DMB/4-1], 32'hA5A5_5A5A);
      do_op(3'd3, 32'h2FFF, 32'h0, 32'h210, rd); check("lb_last_byte", rd, 32'hFFFFFFA5);
      do_op(3'd4, 32'h3000, 32'h0, 32'h214, rd);

      // Back-to-back: SB then LW on the same word with req_valid held.
      model(3'd7, 32'h21, 32'h000000C3, exc_e, rd_e, wr_e, lat_e);
      model(3'd0, 32'h20, 32'h0, exc_e, rd_e, wr_e, lat_e);
      req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h21; req_wdata = 32'h000000C3; req_pc = 32'h300;
      @(posedge clk); #1;
      req_op = 3'd0; req_addr = 32'h20; req_wdata = 32'h0; req_pc = 32'h304;
      check("b2b_ready_read", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      check("b2b_ready_write", {31'h0, req_ready}, 32'h0);
      check("b2b_write", {31'h0, mem_write}, 32'h1);
      check("b2b_wdata", mem_wdata, rd_e);
      @(posedge clk); #1;
      check("b2b_resp1", {31'h0, resp_valid}, 32'h1);
      check("b2b_ready_resp", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      check("b2b_ready_idle", {31'h0, req_ready}, 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("b2b_accepted", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      check("b2b_resp2", {31'h0, resp_valid}, 32'h1);
      check("b2b_lw_rdata", resp_rdata, rd_e);
      @(posedge clk); #1;

      // Reset during the WRITE state of an SB.
      old_word = dmem[4];
      req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h10; req_wdata = 32'h55; req_pc = 32'h400;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1; #1;
      check("abort_no_write", {31'h0, mem_write}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
      check("abort_ready", {31'h0, req_ready}, 32'h1);
      check("abort_mem_addr", mem_addr, 32'h0);
      check("abort_mem_wdata", mem_wdata, 32'h0);
      check("abort_mem_pc", mem_pc, 32'h0);
      check("abort_rdata", resp_rdata, 32'h0);
      check("abort_word", dmem[4], old_word);
      @(posedge clk); #1;
      check("abort_still_no_resp", {31'h0, resp_valid}, 32'h0);

      // Randomized ops, mostly on a small window so loads see earlier stores.
      for (int i = 0; i < 200; i++) begin
         op = 3'($urandom_range(0, 7));
         r  = $urandom_range(0, 15);
         if (r == 0)      ad = $urandom;
         else if (r < 3)  ad = 32'(DMB - 8 + $urandom_range(0, 15));
         else             ad = 32'($urandom_range(0, 63));
         do_op(op, ad, $urandom, $urandom, rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
